// File: rtl/rf_ctrl.sv
// rtl/rf_ctrl.sv - micro-op sequencer in front of a single-port register file
// Expands READ/WRITE/MOV/SWAP into one rf access per cycle and pulses done with the result.
module rf_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_ce,
  output logic [ADDR_W-1:0] rf_adr,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, WRB, WRA, DONE} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MOV   = 2'b10;

  state_t            state, state_nxt;
  logic [1:0]        op;
  logic [ADDR_W-1:0] rd, rs;
  logic [DATA_W-1:0] imm, tmp_a, tmp_b, result;
  logic              accept;

  // rst is folded in so the handshake is refused even in the reset cycle itself
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      rd      <= '0;
      rs      <= '0;
      imm     <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= cmd_op;
        rd  <= cmd_rd;
        rs  <= cmd_rs;
        imm <= cmd_imm;
      end
      if (state == RDA) tmp_a <= rf_data_out;
      if (state == RDB) tmp_b <= rf_data_out;
      if (state_nxt == DONE) rd_data <= result;
    end
  end

  always_comb begin
    state_nxt  = state;
    result     = tmp_a;
    done       = 1'b0;
    rf_ce      = 1'b0;
    rf_adr     = '0;
    rf_data_in = '0;
    // READ finishes straight out of RDA, so its result bypasses tmp_a
    if (op == OP_WRITE)   result = imm;
    else if (state == RDA) result = rf_data_out;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_WRITE) ? WRB : RDA;
      RDA: begin
        rf_adr = rs;
        if (op == OP_READ)     state_nxt = DONE;
        else if (op == OP_MOV) state_nxt = WRB;
        else                   state_nxt = RDB;
      end
      RDB: begin
        rf_adr    = rd;
        state_nxt = WRB;
      end
      WRB: begin
        rf_adr     = rd;
        rf_ce      = 1'b1;
        rf_data_in = (op == OP_WRITE) ? imm : tmp_a;
        state_nxt  = (op == OP_READ || op == OP_WRITE || op == OP_MOV) ? DONE : WRA;
      end
      WRA: begin
        rf_adr     = rs;
        rf_ce      = 1'b1;
        rf_data_in = tmp_b;
        state_nxt  = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_ctrl.sv
// tb/tb_rf_ctrl.sv - self-checking bench for rf_ctrl
// Register file modelled as an array; expectations come from an op-level reference model.
module tb_rf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs;
  logic [7:0] cmd_imm;
  logic       done;
  logic [7:0] rd_data, rf_data_in, rf_data_out;
  logic       rf_ce;
  logic [2:0] rf_adr;

  logic [7:0] mem [8] = '{default: 8'h00};
  logic [7:0] ref_mem [8] = '{default: 8'h00};
  int n_assert = 0;
  int n_fail   = 0;

  rf_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .done(done), .rd_data(rd_data), .rf_data_in(rf_data_in), .rf_ce(rf_ce),
    .rf_adr(rf_adr), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  assign rf_data_out = mem[rf_adr];
  always @(posedge clk) if (rf_ce) mem[rf_adr] <= rf_data_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    cmd_op  = 2'($urandom);
    cmd_rd  = 3'($urandom);
    cmd_rs  = 3'($urandom);
    cmd_imm = 8'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after done.
  task automatic run_op(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [7:0] imm, input bit hold);
    int lat, n_ce, w;
    int ce_k [2];
    logic [2:0] ce_a [2];
    logic [7:0] ce_d [2];
    logic [7:0] exp_rd;
    bit ce_exp;
    int idx;
    n_ce = 0;
    case (op)
      2'b00: begin lat = 2; exp_rd = ref_mem[rs]; end
      2'b01: begin lat = 2; exp_rd = imm;
                   ce_k[0] = 1; ce_a[0] = rd; ce_d[0] = imm; n_ce = 1; end
      2'b10: begin lat = 3; exp_rd = ref_mem[rs];
                   ce_k[0] = 2; ce_a[0] = rd; ce_d[0] = ref_mem[rs]; n_ce = 1; end
      default: begin lat = 5; exp_rd = ref_mem[rs];
                   ce_k[0] = 3; ce_a[0] = rd; ce_d[0] = ref_mem[rs];
                   ce_k[1] = 4; ce_a[1] = rs; ce_d[1] = ref_mem[rd]; n_ce = 2; end
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk("accept_wait", 32'(w < 20), 32'd1);
    @(posedge clk); #1;
    if (hold) rand_fields(); else begin cmd_valid = 1'b0; rand_fields(); end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      ce_exp = 1'b0; idx = 0;
      for (int i = 0; i < n_ce; i++) if (ce_k[i] == k) begin ce_exp = 1'b1; idx = i; end
      chk($sformatf("done_k%0d", k), 32'(done), 32'(k == lat));
      chk($sformatf("cmd_ready_k%0d", k), 32'(cmd_ready), 32'(k > lat));
      chk($sformatf("rf_ce_k%0d", k), 32'(rf_ce), 32'(ce_exp));
      if (ce_exp) begin
        chk($sformatf("rf_adr_k%0d", k), 32'(rf_adr), 32'(ce_a[idx]));
        chk($sformatf("rf_data_in_k%0d", k), 32'(rf_data_in), 32'(ce_d[idx]));
      end
      if (k >= lat) chk($sformatf("rd_data_k%0d", k), 32'(rd_data), 32'(exp_rd));
      if (k == lat + 1) begin
        chk("idle_adr", 32'(rf_adr), 32'd0);
        chk("idle_data_in", 32'(rf_data_in), 32'd0);
        cmd_valid = 1'b0;
      end else if (hold) rand_fields();
    end
    case (op)
      2'b01: ref_mem[rd] = imm;
      2'b10: ref_mem[rd] = ref_mem[rs];
      2'b11: begin exp_rd = ref_mem[rd]; ref_mem[rd] = ref_mem[rs]; ref_mem[rs] = exp_rd; end
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rand_fields();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_ce", 32'(rf_ce), 32'd0);
    chk("rst_rf_adr", 32'(rf_adr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    run_op(2'b01, 3'd3, 3'd0, 8'hA5, 1'b0);
    run_op(2'b00, 3'd0, 3'd3, 8'h00, 1'b0);
    run_op(2'b10, 3'd5, 3'd3, 8'h00, 1'b0);
    run_op(2'b00, 3'd0, 3'd5, 8'h00, 1'b0);
    run_op(2'b01, 3'd1, 3'd0, 8'h11, 1'b0);
    run_op(2'b01, 3'd2, 3'd0, 8'h22, 1'b0);
    run_op(2'b11, 3'd1, 3'd2, 8'h00, 1'b0);
    chk("swap_r1", 32'(mem[1]), 32'h22);
    chk("swap_r2", 32'(mem[2]), 32'h11);
    run_op(2'b01, 3'd4, 3'd0, 8'h5C, 1'b0);
    run_op(2'b11, 3'd4, 3'd4, 8'h00, 1'b0);
    run_op(2'b00, 3'd0, 3'd4, 8'h00, 1'b0);
    run_op(2'b11, 3'd6, 3'd3, 8'h00, 1'b1);

    // reset during the WRA cycle of a SWAP
    run_op(2'b01, 3'd1, 3'd0, 8'h11, 1'b0);
    run_op(2'b01, 3'd2, 3'd0, 8'h22, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rd = 3'd1; cmd_rs = 3'd2;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wra_ce", 32'(rf_ce), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_ce", 32'(rf_ce), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("after_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_rst_no_done", 32'(done), 32'd0);
    end
    chk("rst_r1", 32'(mem[1]), 32'h22);
    chk("rst_r2", 32'(mem[2]), 32'h22);
    ref_mem[1] = 8'h22;

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
